// File: rtl/dmem_ctrl.sv
// Data-memory controller: core dreq/dready_n handshake to a byte-lane synchronous SRAM,
// with programmable wait states, lane steering and misaligned/out-of-range fault detection.
module dmem_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dreq,
    input  logic              dwrite,
    input  logic [1:0]        dsize,
    input  logic [31:0]       daddr,
    inout  wire  [31:0]       ddata,
    output logic              dbusy,
    output logic              dready_n,
    output logic              derr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic              first_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic              err_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              req_fault;
    logic              last_access;
    logic [31:0]       rd_lane;

    always_comb begin
        req_fault = 1'b0;
        case (dsize)
            2'b01:   req_fault = daddr[0];
            2'b10:   req_fault = |daddr[1:0];
            2'b11:   req_fault = 1'b1;
            default: req_fault = 1'b0;
        endcase
        if ((daddr >> ADDR_W) != 32'd0)
            req_fault = 1'b1;
    end

    // First ACCESS cycle is tracked by first_q so the 4-bit counter only has to span
    // WAIT_CYCLES..0, keeping WAIT_CYCLES=15 representable.
    assign last_access = (state_q == ACCESS) && !first_q && (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dreq) state_d = req_fault ? RESP : ACCESS;
            ACCESS:  if (last_access) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            first_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (state_q == IDLE && dreq) begin
            addr_q  <= daddr[ADDR_W-1:0];
            size_q  <= dsize;
            write_q <= dwrite;
            wdata_q <= ddata;
            err_q   <= req_fault;
            first_q <= ~req_fault;
            cnt_q   <= 4'(WAIT_CYCLES);
        end else if (state_q == ACCESS) begin
            if (first_q)
                first_q <= 1'b0;
            else if (cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;
            if (last_access)
                rdata_q <= mem_rdata;
        end
    end

    assign dbusy    = (state_q == ACCESS);
    assign dready_n = (state_q != RESP);
    assign derr     = (state_q == RESP) && err_q;
    assign mem_en   = (state_q == ACCESS) && first_q;
    assign mem_we   = mem_en && write_q;
    assign mem_addr = addr_q[ADDR_W-1:2];

    always_comb begin
        mem_be = '0;
        if (mem_en) begin
            if (!write_q)
                mem_be = '1;
            else begin
                case (size_q)
                    2'b00:   mem_be = 4'b0001 << addr_q[1:0];
                    2'b01:   mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
                    default: mem_be = '1;
                endcase
            end
        end
    end

    always_comb begin
        case (size_q)
            2'b00:   mem_wdata = {4{wdata_q[7:0]}};
            2'b01:   mem_wdata = {2{wdata_q[15:0]}};
            default: mem_wdata = wdata_q;
        endcase
    end

    always_comb begin
        rd_lane = rdata_q;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'b00:   rd_lane = {24'h0, rdata_q[7:0]};
                    2'b01:   rd_lane = {24'h0, rdata_q[15:8]};
                    2'b10:   rd_lane = {24'h0, rdata_q[23:16]};
                    default: rd_lane = {24'h0, rdata_q[31:24]};
                endcase
            end
            2'b01:   rd_lane = addr_q[1] ? {16'h0, rdata_q[31:16]} : {16'h0, rdata_q[15:0]};
            default: rd_lane = rdata_q;
        endcase
    end

    assign ddata = (state_q == RESP && !write_q) ? (err_q ? 32'h0 : rd_lane) : 32'hz;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: WAIT_CYCLES=1 instance for function/fault/reset tests,
// WAIT_CYCLES=0 instance for back-to-back timing. Undriven ddata reads as all-ones via pullup.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WAIT_CYCLES=1 instance
    logic        rst1, dreq1, dwrite1, drv1;
    logic [1:0]  dsize1;
    logic [31:0] daddr1, wd1;
    wire  [31:0] ddata1;
    logic        dbusy1, dready_n1, derr1, mem_en1, mem_we1;
    logic [3:0]  mem_be1;
    logic [13:0] mem_addr1;
    logic [31:0] mem_wdata1, mem_rdata1;
    logic [31:0] mem1 [0:16383];

    assign ddata1 = drv1 ? wd1 : 32'hz;
    pullup (ddata1);

    dmem_ctrl #(.ADDR_W(16), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst1), .dreq(dreq1), .dwrite(dwrite1), .dsize(dsize1),
        .daddr(daddr1), .ddata(ddata1), .dbusy(dbusy1), .dready_n(dready_n1),
        .derr(derr1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_be(mem_be1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    always @(posedge clk) begin
        if (mem_en1) begin
            if (mem_we1) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be1[i]) mem1[mem_addr1][8*i +: 8] <= mem_wdata1[8*i +: 8];
            end else
                mem_rdata1 <= mem1[mem_addr1];
        end
    end

    // WAIT_CYCLES=0 instance; its SRAM returns a tag derived from the word address
    logic        rst0, dreq0, dwrite0;
    logic [1:0]  dsize0;
    logic [31:0] daddr0;
    wire  [31:0] ddata0;
    logic        dbusy0, dready_n0, derr0, mem_en0, mem_we0;
    logic [3:0]  mem_be0;
    logic [13:0] mem_addr0;
    logic [31:0] mem_wdata0, mem_rdata0;

    pullup (ddata0);

    dmem_ctrl #(.ADDR_W(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .dreq(dreq0), .dwrite(dwrite0), .dsize(dsize0),
        .daddr(daddr0), .ddata(ddata0), .dbusy(dbusy0), .dready_n(dready_n0),
        .derr(derr0), .mem_en(mem_en0), .mem_we(mem_we0), .mem_be(mem_be0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    always @(posedge clk)
        if (mem_en0 && !mem_we0) mem_rdata0 <= 32'hA500_0000 | {18'h0, mem_addr0};

    // Results of the last access on dut1
    logic [31:0] rd, mw;
    logic        er, mwe;
    logic [3:0]  be;
    logic [13:0] ma;
    int          lat, bcyc, ecyc;

    // Core-side transaction on dut1: hold dreq until dready_n, latency counted in edges from accept
    task automatic access1(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd);
        logic done;
        @(negedge clk);
        dreq1 = 1'b1; dwrite1 = wr; dsize1 = sz; daddr1 = addr; wd1 = wd; drv1 = wr;
        @(posedge clk);
        lat = 1; bcyc = 0; ecyc = 0; done = 1'b0;
        rd = '0; er = 1'b0; be = '0; ma = '0; mw = '0; mwe = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            if (dbusy1) bcyc++;
            if (mem_en1) begin
                ecyc++; be = mem_be1; ma = mem_addr1; mw = mem_wdata1; mwe = mem_we1;
            end
            if (!dready_n1) begin
                done = 1'b1; rd = ddata1; er = derr1;
            end else begin
                @(posedge clk);
                lat++;
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL timeout addr=%h got no dready_n want completion", addr); end
        dreq1 = 1'b0; drv1 = 1'b0;
    endtask

    task automatic test_reset();
        rst1 = 1'b0; rst0 = 1'b0;
        dreq1 = 0; dwrite1 = 0; dsize1 = 0; daddr1 = 0; wd1 = 0; drv1 = 0;
        dreq0 = 0; dwrite0 = 0; dsize0 = 0; daddr0 = 0;
        repeat (3) @(negedge clk);
        checks++; if (dbusy1 !== 1'b0)    begin errors++; $display("FAIL rst_dbusy got %b want 0", dbusy1); end
        checks++; if (dready_n1 !== 1'b1) begin errors++; $display("FAIL rst_dready_n got %b want 1", dready_n1); end
        checks++; if (derr1 !== 1'b0)     begin errors++; $display("FAIL rst_derr got %b want 0", derr1); end
        checks++; if ({mem_en1, mem_we1, mem_be1} !== 6'b0) begin errors++; $display("FAIL rst_mem_ctl got %b want 000000", {mem_en1, mem_we1, mem_be1}); end
        checks++; if (mem_addr1 !== 14'h0)  begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr1); end
        checks++; if (mem_wdata1 !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata1); end
        checks++; if (ddata1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_ddata_hiz got %h want ffffffff(pulled)", ddata1); end
        rst1 = 1'b1; rst0 = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        access1(1'b1, 2'b10, 32'h0100, 32'hDEAD_BEEF);
        checks++; if (be !== 4'b1111)      begin errors++; $display("FAIL wst_be got %b want 1111", be); end
        checks++; if (ma !== 14'h040)      begin errors++; $display("FAIL wst_addr got %h want 040", ma); end
        checks++; if (mw !== 32'hDEAD_BEEF || mwe !== 1'b1) begin errors++; $display("FAIL wst_wdata got %h/%b want deadbeef/1", mw, mwe); end
        checks++; if (ecyc != 1 || lat != 4) begin errors++; $display("FAIL wst_timing got en=%0d lat=%0d want 1/4", ecyc, lat); end
        access1(1'b0, 2'b10, 32'h0100, 32'h0);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wld_data got %h want deadbeef", rd); end
        checks++; if (lat != 4 || bcyc != 3) begin errors++; $display("FAIL wld_timing got lat=%0d busy=%0d want 4/3", lat, bcyc); end
        checks++; if (be !== 4'b1111 || mwe !== 1'b0 || er !== 1'b0) begin errors++; $display("FAIL wld_ctl got be=%b we=%b err=%b want 1111/0/0", be, mwe, er); end
    endtask

    task automatic test_byte();
        logic [7:0]  bytes [4];
        logic [3:0]  exp_be [4];
        bytes  = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_be = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            access1(1'b1, 2'b00, 32'h0200 + 32'(i), {24'h0, bytes[i]});
            checks++; if (be !== exp_be[i] || mw !== {4{bytes[i]}}) begin errors++; $display("FAIL bst%0d got be=%b wd=%h want %b/%h", i, be, mw, exp_be[i], {4{bytes[i]}}); end
        end
        access1(1'b0, 2'b10, 32'h0200, 32'h0);
        checks++; if (rd !== 32'h4433_2211) begin errors++; $display("FAIL bld_word got %h want 44332211", rd); end
        access1(1'b0, 2'b00, 32'h0202, 32'h0);
        checks++; if (rd !== 32'h0000_0033) begin errors++; $display("FAIL bld_byte got %h want 00000033", rd); end
    endtask

    task automatic test_half();
        access1(1'b1, 2'b01, 32'h0302, 32'h0000_BEEF);
        checks++; if (be !== 4'b1100 || mw !== 32'hBEEF_BEEF) begin errors++; $display("FAIL hst got be=%b wd=%h want 1100/beefbeef", be, mw); end
        access1(1'b0, 2'b01, 32'h0302, 32'h0);
        checks++; if (rd !== 32'h0000_BEEF) begin errors++; $display("FAIL hld got %h want 0000beef", rd); end
    endtask

    task automatic test_fault();
        logic [1:0]  sz [4];
        logic [31:0] ad [4];
        sz = '{2'b10, 2'b01, 2'b11, 2'b10};
        ad = '{32'h0102, 32'h0101, 32'h0100, 32'h0001_0000};
        for (int i = 0; i < 4; i++) begin
            access1(1'b0, sz[i], ad[i], 32'h0);
            checks++; if (er !== 1'b1 || lat != 1) begin errors++; $display("FAIL flt%0d got err=%b lat=%0d want 1/1", i, er, lat); end
            checks++; if (ecyc != 0 || rd !== 32'h0) begin errors++; $display("FAIL flt%0d_mem got en=%0d data=%h want 0/0", i, ecyc, rd); end
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        dreq1 = 1'b1; dwrite1 = 1'b0; dsize1 = 2'b10; daddr1 = 32'h0100;
        @(posedge clk);
        @(posedge clk);
        #2 rst1 = 1'b0;
        #1;
        checks++; if (dbusy1 !== 1'b0 || dready_n1 !== 1'b1 || mem_en1 !== 1'b0) begin errors++; $display("FAIL midrst_ctl got busy=%b rdy_n=%b en=%b want 0/1/0", dbusy1, dready_n1, mem_en1); end
        checks++; if (ddata1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midrst_ddata_hiz got %h want ffffffff(pulled)", ddata1); end
        dreq1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (!dready_n1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_pulse got dready_n pulse want none"); end
        access1(1'b0, 2'b10, 32'h0100, 32'h0);
        checks++; if (rd !== 32'hDEAD_BEEF || lat != 4) begin errors++; $display("FAIL midrst_reload got %h lat=%0d want deadbeef/4", rd, lat); end
    endtask

    task automatic test_back_to_back();
        int npulse, nen, t1, t2;
        logic [31:0] d1, d2;
        logic bad;
        npulse = 0; nen = 0; t1 = 0; t2 = 0; d1 = '0; d2 = '0; bad = 1'b0;
        @(negedge clk);
        dreq0 = 1'b1; dwrite0 = 1'b0; dsize0 = 2'b10; daddr0 = 32'h0040;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_en0) begin
                nen++;
                if (mem_we0 !== 1'b0 || mem_be0 !== 4'b1111) bad = 1'b1;
            end
            if (!dready_n0) begin
                npulse++;
                if (derr0 !== 1'b0 || dbusy0 !== 1'b0) bad = 1'b1;
                if (npulse == 1) begin t1 = k; d1 = ddata0; daddr0 = 32'h0044; end
                else if (npulse == 2) begin t2 = k; d2 = ddata0; dreq0 = 1'b0; end
            end
        end
        checks++; if (t1 != 3 || t2 != 7) begin errors++; $display("FAIL b2b_timing got t1=%0d t2=%0d want 3/7", t1, t2); end
        checks++; if (d1 !== 32'hA500_0010 || d2 !== 32'hA500_0011) begin errors++; $display("FAIL b2b_data got %h/%h want a5000010/a5000011", d1, d2); end
        checks++; if (npulse != 2 || nen != 2) begin errors++; $display("FAIL b2b_count got pulses=%0d en=%0d want 2/2", npulse, nen); end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL b2b_ctl got bad strobe state want clean"); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_fault();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller downstream of the core's memory-access stage.
- Accepts the core's data-bus requests (dreq, dwrite, dsize, daddr, bidirectional ddata) and answers with the dbusy/dready_n handshake.
- Drives a single-port synchronous SRAM with byte lanes and inserts a configurable number of wait states.
- Performs byte/half/word lane steering and detects misaligned or out-of-range accesses.

Parameters:
- ADDR_W, 16: byte-address width decoded by memory; legal daddr range is 0 .. 2^ADDR_W-1.
- WAIT_CYCLES, 1: extra wait states per access, 0..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- dreq  input  1  core request strobe.
- dwrite  input  1  1 = store, 0 = load; sampled with dreq.
- dsize  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- daddr  input  32  byte address.
- ddata  inout  32  store data (core drives it) / load data (block drives it during RESP of a read only, otherwise high-Z).
- dbusy  output  1  high while an access is in progress.
- dready_n  output  1  active-low one-cycle completion strobe.
- derr  output  1  pulses with dready_n when the access faulted.
- mem_en  output  1  SRAM access enable.
- mem_we  output  1  SRAM write enable.
- mem_be  output  4  SRAM byte enables; bit i selects bits [8i+7:8i].
- mem_addr  output  ADDR_W-2  SRAM word address.
- mem_wdata  output  32  SRAM write data, lane-aligned.
- mem_rdata  input  32  SRAM read data; valid the cycle after mem_en and held until the next mem_en.

Behaviour:
- Reset (rst=0, async):
  - State is IDLE; the wait counter is cleared.
  - dbusy=0, dready_n=1, derr=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - ddata is high-Z.
  - Reset asserted mid-access aborts the access: no write is completed after reset, and no dready_n pulse is issued for the aborted request.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, on dreq=1:
  - Latch daddr, dsize, dwrite and ddata (store data).
  - Go to ACCESS and set dbusy=1 from the next cycle.
  - If the access is faulty, go to RESP directly instead, with derr armed and no SRAM activity.
  - An access is faulty when any of these hold: dsize=11; half with addr[0]=1; word with addr[1:0]!=0; daddr >= 2^ADDR_W.
- ACCESS:
  - Lasts exactly WAIT_CYCLES+2 cycles, counted by a 4-bit counter.
  - mem_en=1 in the first ACCESS cycle only; mem_we, mem_be, mem_addr (=addr[ADDR_W-1:2]) and mem_wdata are valid in that cycle.
  - The read word is captured from mem_rdata in the last ACCESS cycle.
  - At the end of the last cycle, go to RESP.
- RESP (one cycle), then IDLE:
  - dready_n=0, dbusy=0, derr=armed flag.
  - For a read, ddata is driven with the right-aligned, zero-extended lane data: byte = byte lane addr[1:0]; half = lanes addr[1]*2 .. +1; word = full word.
  - For a faulted read, ddata is driven with 0.
  - Sign extension is the core's job.
- Store lane steering:
  - byte: mem_be = 1 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - half: mem_be = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
  - word: mem_be = 1111; mem_wdata = wdata.
  - Read: mem_be = 1111, mem_we = 0.
- Request timing:
  - dreq seen outside IDLE is ignored; the core holds dreq until it sees dready_n=0.
  - dreq in RESP is not accepted; the earliest next accept is the cycle after RESP.
- Latency:
  - Request accepted at edge T gives dready_n low in cycle T+WAIT_CYCLES+3.
  - A faulted request gives dready_n low in cycle T+1.
- Outside the first ACCESS cycle, mem_en=0, mem_we=0 and mem_be=0.

Test Plan:
- Word store/load, WAIT_CYCLES=1: store 0xDEADBEEF to 0x0100, then load 0x0100.
  - mem_be=1111 and mem_addr=0x040 on the store.
  - The load returns ddata=0xDEADBEEF with dready_n low exactly 4 cycles after accept; dbusy is high during the 3 ACCESS cycles.
- Byte stores: store bytes 0x11, 0x22, 0x33, 0x44 to 0x0200..0x0203.
  - mem_be walks 0001, 0010, 0100, 1000.
  - A word load then returns 0x44332211.
  - A byte load of 0x0202 returns 0x00000033.
- Half access: store half 0xBEEF at 0x0302 (expect mem_be=1100), then load half 0x0302.
  - The load returns 0x0000BEEF.
- Fault cases: word load at 0x0102, half at 0x0101, dsize=11, and daddr=0x00010000 (ADDR_W=16).
  - Each gives derr=1 with dready_n in cycle T+1, mem_en never asserted, and ddata=0 for reads.
- Reset mid-access: assert rst in the second ACCESS cycle of a load.
  - Outputs go to reset values immediately and ddata is high-Z.
  - No dready_n pulse follows.
  - A new load after reset completes normally.
- Back-to-back with WAIT_CYCLES=0: hold dreq high across two loads.
  - Second accept occurs the cycle after RESP.
  - dready_n pulses are exactly 4 cycles apart.
  - dreq during ACCESS/RESP is not double-accepted.
